hex_display_ctrl: RTL and testbench
===================================

HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, number of seven-segment digits driven (legal 1..8).
REQ-002 SHALL have parameter CLK_FREQ_HZ, default 50000000, input clock frequency.
REQ-003 SHALL have parameter BLINK_HZ, default 2, reset blink toggle rate; the reset divider is DIV_RST = CLK_FREQ_HZ/(2*BLINK_HZ) (integer division).
REQ-004 SHALL have parameter ACTIVE_LOW, default 1; 1 means segment lit = 0, 0 means segment lit = 1.
REQ-005 clk_50Mhz  input  1  single clock; all logic on rising edge.
REQ-006 reset_n  input  1  reset; asynchronous, active-low.
REQ-007 address  input  2  Avalon-MM word address.
REQ-008 write  input  1  Avalon write strobe.
REQ-009 writedata  input  32  Avalon write data.
REQ-010 read  input  1  Avalon read strobe.
REQ-011 readdata  output  32  Avalon read data, fixed read latency 1.
REQ-012 hex_pins  output  7*NUM_DIGITS  segments; digit k at [7k+6:7k], bit order gfedcba.

Function
REQ-013 Register map: 0 VALUE (RW; nibble k = digit k value, bits above 4*NUM_DIGITS read 0); 1 BLANK (RW; bit k=1 blanks digit k); 2 BLINK (RW; bit k=1 blinks digit k); 3 DIV (RW; 32-bit blink half-period in clocks).
REQ-014 Writes take effect at the clock edge where write=1; unimplemented bits ignored on write, read 0.
REQ-015 readdata SHALL present the addressed register one cycle after read=1 and hold that value until the next read; read and write in the same cycle to the same address return the pre-write value.
REQ-016 Blink counter: 32-bit, increments each clock while DIV != 0; on reaching DIV-1 it wraps to 0 and blink phase toggles.
REQ-017 DIV = 0 SHALL disable blinking: counter held at 0, phase forced to 1 (visible).
REQ-018 Any write to DIV SHALL clear the counter to 0 and set phase to 1 in that same edge.
REQ-019 Digit k is dark when BLANK[k]=1, or when BLINK[k]=1 and phase=0; BLANK has priority; otherwise digit k shows hex glyph of VALUE nibble k.
REQ-020 Glyphs (active-high gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; dark = 00; when ACTIVE_LOW=1 output is bitwise inverted.
REQ-021 hex_pins SHALL be registered; a register write or phase toggle at edge N is visible on hex_pins after edge N+1 (latency 1 cycle).
REQ-022 Digits update simultaneously; no multiplexing or per-digit skew.

Reset
REQ-023 On reset_n=0, asynchronously: VALUE=0, BLANK=0, BLINK=0, DIV=DIV_RST, counter=0, phase=1, readdata=0, hex_pins = glyph 0 on every digit (7'h40 per digit when ACTIVE_LOW=1).
REQ-024 Reset asserted mid-blink or mid-read SHALL abort immediately; first read after deassertion returns reset values.

Verification
REQ-025 Reset, then write VALUE=0x00A5C3 -> hex_pins (ACTIVE_LOW=1, 6 digits) digits 0..5 = 30,46,12,08,40,40 two cycles later.
REQ-026 Write BLANK=0x3 then read address 1 -> readdata=0x00000003 one cycle after read; digits 0,1 = 7F, others unchanged.
REQ-027 DIV=4, BLINK=0x1, VALUE=0x8 -> digit 0 alternates 7F/00 every 4 clocks; digits 1..5 steady 40.
REQ-028 DIV=0 with BLINK=0x3F -> all digits steady visible; then write DIV=3 -> first dark phase starts exactly 3 clocks after the write edge (+1 output latency).
REQ-029 BLANK=0x1 and BLINK=0x1 concurrently -> digit 0 remains 7F in both phases.
REQ-030 Assert reset_n low mid-blink for 1 cycle -> hex_pins immediately all 40, DIV reads DIV_RST=12500000, counter restarts from 0.

Source files
------------

// File: rtl/hex_display_ctrl.sv
// Avalon-MM slave driving NUM_DIGITS seven-segment hex digits.
// It supports per-digit blanking and blinking from a shared programmable blink divider.
module hex_display_ctrl #(
   parameter int NUM_DIGITS  = 6,
   parameter int CLK_FREQ_HZ = 50000000,
   parameter int BLINK_HZ    = 2,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic                    clk_50Mhz,
   input  logic                    reset_n,
   input  logic [1:0]              address,
   input  logic                    write,
   input  logic [31:0]             writedata,
   input  logic                    read,
   output logic [31:0]             readdata,
   output logic [7*NUM_DIGITS-1:0] hex_pins
);

   localparam logic [31:0] DIV_RST = 32'(CLK_FREQ_HZ / (2 * BLINK_HZ));
   localparam logic [6:0]  ZERO_PIN = (ACTIVE_LOW != 0) ? 7'h40 : 7'h3F;
   localparam logic [7*NUM_DIGITS-1:0] HEX_RST = {NUM_DIGITS{ZERO_PIN}};

   logic [4*NUM_DIGITS-1:0] value_q, value_d;
   logic [NUM_DIGITS-1:0]   blank_q, blank_d;
   logic [NUM_DIGITS-1:0]   blink_q, blink_d;
   logic [31:0]             div_q, div_d;
   logic [31:0]             cnt_q, cnt_d;
   logic                    phase_q, phase_d;
   logic [31:0]             readdata_q, readdata_d;
   logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
   logic [31:0]             rd_mux;
   logic                    wr_div;

   function automatic logic [6:0] glyph(input logic [3:0] nib);
      logic [6:0] g;
      case (nib)
         4'h0:    g = 7'h3F;
         4'h1:    g = 7'h06;
         4'h2:    g = 7'h5B;
         4'h3:    g = 7'h4F;
         4'h4:    g = 7'h66;
         4'h5:    g = 7'h6D;
         4'h6:    g = 7'h7D;
         4'h7:    g = 7'h07;
         4'h8:    g = 7'h7F;
         4'h9:    g = 7'h6F;
         4'hA:    g = 7'h77;
         4'hB:    g = 7'h7C;
         4'hC:    g = 7'h39;
         4'hD:    g = 7'h5E;
         4'hE:    g = 7'h79;
         4'hF:    g = 7'h71;
         default: g = 7'h00;
      endcase
      return g;
   endfunction

   function automatic logic [6:0] seg_out(input logic [3:0] nib, input logic dark);
      logic [6:0] seg;
      seg = dark ? 7'h00 : glyph(nib);
      return (ACTIVE_LOW != 0) ? ~seg : seg;
   endfunction

   assign wr_div = write && (address == 2'd3);

   // Register file write decode
   always_comb begin
      value_d = value_q;
      blank_d = blank_q;
      blink_d = blink_q;
      div_d   = div_q;
      if (write) begin
         case (address)
            2'd0:    value_d = writedata[4*NUM_DIGITS-1:0];
            2'd1:    blank_d = writedata[NUM_DIGITS-1:0];
            2'd2:    blink_d = writedata[NUM_DIGITS-1:0];
            2'd3:    div_d   = writedata;
            default: value_d = value_q;
         endcase
      end else begin
         value_d = value_q;
      end
   end

   // Read mux; samples pre-write register contents so same-cycle read/write returns old data
   always_comb begin
      rd_mux = 32'd0;
      case (address)
         2'd0:    rd_mux[4*NUM_DIGITS-1:0] = value_q;
         2'd1:    rd_mux[NUM_DIGITS-1:0]   = blank_q;
         2'd2:    rd_mux[NUM_DIGITS-1:0]   = blink_q;
         2'd3:    rd_mux                   = div_q;
         default: rd_mux                   = 32'd0;
      endcase
      if (read) begin
         readdata_d = rd_mux;
      end else begin
         readdata_d = readdata_q;
      end
   end

   // Blink divider: a DIV write restarts the half-period in the visible phase
   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (wr_div) begin
         cnt_d   = 32'd0;
         phase_d = 1'b1;
      end else if (div_q == 32'd0) begin
         cnt_d   = 32'd0;
         phase_d = 1'b1;
      end else if (cnt_q >= div_q - 32'd1) begin
         cnt_d   = 32'd0;
         phase_d = ~phase_q;
      end else begin
         cnt_d   = cnt_q + 32'd1;
      end
   end

   // Segment decode for all digits in parallel; BLANK overrides BLINK
   always_comb begin
      hex_d = {(7*NUM_DIGITS){1'b0}};
      for (int k = 0; k < NUM_DIGITS; k++) begin
         hex_d[7*k +: 7] = seg_out(value_q[4*k +: 4],
                                   blank_q[k] || (blink_q[k] && !phase_q));
      end
   end

   // State and output registers
   always_ff @(posedge clk_50Mhz or negedge reset_n) begin
      if (!reset_n) begin
         value_q    <= {(4*NUM_DIGITS){1'b0}};
         blank_q    <= {NUM_DIGITS{1'b0}};
         blink_q    <= {NUM_DIGITS{1'b0}};
         div_q      <= DIV_RST;
         cnt_q      <= 32'd0;
         phase_q    <= 1'b1;
         readdata_q <= 32'd0;
         hex_q      <= HEX_RST;
      end else begin
         value_q    <= value_d;
         blank_q    <= blank_d;
         blink_q    <= blink_d;
         div_q      <= div_d;
         cnt_q      <= cnt_d;
         phase_q    <= phase_d;
         readdata_q <= readdata_d;
         hex_q      <= hex_d;
      end
   end

   assign readdata = readdata_q;
   assign hex_pins = hex_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed self-checking bench for hex_display_ctrl with default parameters.
// The default parameters are six digits, active-low segments, and DIV_RST = 12500000.
module tb_hex_display_ctrl;

   logic        clk_50Mhz;
   logic        reset_n;
   logic [1:0]  address;
   logic        write;
   logic [31:0] writedata;
   logic        read;
   logic [31:0] readdata;
   logic [41:0] hex_pins;

   int tests;
   int fails;

   hex_display_ctrl dut (
      .clk_50Mhz (clk_50Mhz),
      .reset_n   (reset_n),
      .address   (address),
      .write     (write),
      .writedata (writedata),
      .read      (read),
      .readdata  (readdata),
      .hex_pins  (hex_pins)
   );

   initial clk_50Mhz = 1'b0;
   always #5 clk_50Mhz = ~clk_50Mhz;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk_50Mhz);
      address   = a;
      writedata = d;
      write     = 1'b1;
      @(negedge clk_50Mhz);
      write     = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a);
      @(negedge clk_50Mhz);
      address = a;
      read    = 1'b1;
      @(negedge clk_50Mhz);
      read    = 1'b0;
   endtask

   initial begin
      logic [41:0] exp_hex;
      logic [31:0] held;
      tests     = 0;
      fails     = 0;
      reset_n   = 1'b0;
      address   = 2'd0;
      write     = 1'b0;
      writedata = 32'd0;
      read      = 1'b0;

      #12;
      check("rst_hex", 64'(hex_pins), 64'({6{7'h40}}));
      check("rst_rdata", 64'(readdata), 64'd0);
      @(negedge clk_50Mhz);
      reset_n = 1'b1;

      rd(2'd3);
      check("rst_div", 64'(readdata), 64'd12500000);
      rd(2'd0);
      check("rst_value", 64'(readdata), 64'd0);

      // VALUE write: unchanged right after the write edge, updated one edge later
      wr(2'd0, 32'hFF00A5C3);
      check("value_lat0", 64'(hex_pins), 64'({6{7'h40}}));
      @(negedge clk_50Mhz);
      check("value_hex", 64'(hex_pins), 64'({7'h40, 7'h40, 7'h08, 7'h12, 7'h46, 7'h30}));
      rd(2'd0);
      check("value_rd", 64'(readdata), 64'h0000A5C3);

      wr(2'd1, 32'h00000003);
      rd(2'd1);
      check("blank_rd", 64'(readdata), 64'h00000003);
      check("blank_hex", 64'(hex_pins), 64'({7'h40, 7'h40, 7'h08, 7'h12, 7'h7F, 7'h7F}));
      held = readdata;
      address = 2'd0;
      repeat (3) @(negedge clk_50Mhz);
      check("rdata_hold", 64'(readdata), 64'(held));

      // Read and write BLANK in the same cycle returns the old contents
      @(negedge clk_50Mhz);
      address   = 2'd1;
      writedata = 32'hFFFFFFFF;
      write     = 1'b1;
      read      = 1'b1;
      @(negedge clk_50Mhz);
      write     = 1'b0;
      read      = 1'b0;
      check("rw_same", 64'(readdata), 64'h00000003);
      rd(2'd1);
      check("blank_mask", 64'(readdata), 64'h0000003F);
      wr(2'd1, 32'h00000000);

      // Blink DIV=4 on digit 0 showing '8' (pins 00 lit, 7F dark)
      wr(2'd0, 32'h00000008);
      wr(2'd2, 32'h00000001);
      wr(2'd3, 32'd4);
      for (int j = 0; j <= 12; j++) begin
         if (j > 0) @(negedge clk_50Mhz);
         exp_hex = {{5{7'h40}}, ((j >= 1) && ((((j - 1) / 4) % 2) == 1)) ? 7'h7F : 7'h00};
         check($sformatf("blink4_%0d", j), 64'(hex_pins), 64'(exp_hex));
      end

      // BLANK wins over BLINK in both phases
      wr(2'd1, 32'h00000001);
      @(negedge clk_50Mhz);
      for (int j = 0; j < 10; j++) begin
         check($sformatf("blank_pri_%0d", j), 64'(hex_pins[6:0]), 64'(7'h7F));
         @(negedge clk_50Mhz);
      end
      wr(2'd1, 32'h00000000);

      // DIV=0 holds everything visible
      wr(2'd3, 32'd0);
      wr(2'd2, 32'h0000003F);
      @(negedge clk_50Mhz);
      for (int j = 0; j < 8; j++) begin
         check($sformatf("div0_%0d", j), 64'(hex_pins), 64'({{5{7'h40}}, 7'h00}));
         @(negedge clk_50Mhz);
      end

      // DIV=3: first dark phase visible 4 samples after the write edge
      wr(2'd3, 32'd3);
      for (int j = 0; j <= 9; j++) begin
         if (j > 0) @(negedge clk_50Mhz);
         exp_hex = ((j >= 1) && ((((j - 1) / 3) % 2) == 1)) ? {6{7'h7F}} : {{5{7'h40}}, 7'h00};
         check($sformatf("div3_%0d", j), 64'(hex_pins), 64'(exp_hex));
      end

      // Asynchronous reset mid-blink
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_hex", 64'(hex_pins), 64'({6{7'h40}}));
      check("arst_rdata", 64'(readdata), 64'd0);
      @(negedge clk_50Mhz);
      reset_n = 1'b1;
      rd(2'd3);
      check("arst_div", 64'(readdata), 64'd12500000);
      rd(2'd2);
      check("arst_blink", 64'(readdata), 64'd0);
      for (int j = 0; j < 3; j++) begin
         @(negedge clk_50Mhz);
         check($sformatf("arst_steady_%0d", j), 64'(hex_pins), 64'({6{7'h40}}));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
